// File: rtl/conv3x3_window.sv
// conv3x3_window: 3x3 sliding-window filter over column beats from three line-buffer banks.
// Each accepted beat is one image column (top/mid/bot pixel). One filtered pixel is
// produced per column, tagged with its column index. The left edge is replicated on the
// first column. The right edge is replicated by an automatic flush after the last column.
module conv3x3_window #(
  parameter int IMG_W = 256,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         bank0_pix,
  input  logic [PIX_W-1:0]         bank1_pix,
  input  logic [PIX_W-1:0]         bank2_pix,
  input  logic [2:0]               top_sel,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic [PIX_W-1:0]         out_pix,
  output logic [$clog2(IMG_W)-1:0] out_col
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int COLP  = 3 * PIX_W;    // one column packed as {top, mid, bot}
  localparam int SW    = 13;           // signed width covering every kernel result

  // Front end: column counter and the two most recent columns.
  logic [COL_W-1:0] col_q, col_d;
  logic [COLP-1:0]  win_c_q, win_c_d;  // column k-1 after accepting column k
  logic [COLP-1:0]  win_r_q, win_r_d;  // column k   after accepting column k
  logic             flush_q, flush_d;  // the last column still has to be emitted

  // Stage 1: captured window, mode and column tag.
  logic             s1_vld_q, s1_vld_d;
  logic [1:0]       s1_mode_q;
  logic [COL_W-1:0] s1_col_q, s1_col_d;
  logic [COLP-1:0]  s1_l_q, s1_c_q, s1_r_q, s1_r_d;

  // Stage 2: kernel sum.
  logic                 s2_vld_q;
  logic [1:0]           s2_mode_q;
  logic [COL_W-1:0]     s2_col_q;
  logic signed [SW-1:0] s2_val_q, s2_val_d;

  logic [COLP-1:0]      new_col;
  logic [PIX_W-1:0]     pix_d;
  logic signed [SW-1:0] abs_v;
  logic signed [SW-1:0] tl, ml, bl, tc, mc, bc, tr, mr, br;
  logic                 col_last;

  // Rotate the three banks into top/mid/bot order. A non-one-hot select behaves like 001.
  always_comb begin
    new_col = {bank0_pix, bank1_pix, bank2_pix};
    case (top_sel)
      3'b010:  new_col = {bank1_pix, bank2_pix, bank0_pix};
      3'b100:  new_col = {bank2_pix, bank0_pix, bank1_pix};
      default: new_col = {bank0_pix, bank1_pix, bank2_pix};
    endcase
  end

  assign col_last = (col_q == COL_W'(IMG_W - 1));

  // Next state of the counter, the window, and the stage-1 capture. L and C always come from
  // the held window. R is the incoming column, or C again when flushing the right edge.
  always_comb begin
    col_d    = col_q;
    win_c_d  = win_c_q;
    win_r_d  = win_r_q;
    flush_d  = 1'b0;
    s1_vld_d = 1'b0;
    s1_col_d = s1_col_q;
    s1_r_d   = s1_r_q;
    if (flush_q) begin
      s1_vld_d = 1'b1;
      s1_col_d = COL_W'(IMG_W - 1);
      s1_r_d   = win_r_q;
    end
    if (in_valid) begin
      col_d   = col_last ? '0 : col_q + 1'b1;
      flush_d = col_last;
      win_r_d = new_col;
      if (col_q == '0) begin
        // First column primes the window and doubles as its own left neighbour.
        win_c_d = new_col;
      end else begin
        win_c_d  = win_r_q;
        s1_vld_d = 1'b1;
        s1_col_d = col_q - 1'b1;
        s1_r_d   = new_col;
      end
    end
  end

  // Counter, window and flush registers. start clears them and takes priority over in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      win_c_q <= '0;
      win_r_q <= '0;
      flush_q <= 1'b0;
    end else if (start) begin
      col_q   <= '0;
      win_c_q <= '0;
      win_r_q <= '0;
      flush_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      win_c_q <= win_c_d;
      win_r_q <= win_r_d;
      flush_q <= flush_d;
    end
  end

  // Stage 1: latch the window, mode and column tag of the pixel being emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= '0;
      s1_col_q  <= '0;
      s1_l_q    <= '0;
      s1_c_q    <= '0;
      s1_r_q    <= '0;
    end else if (start) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (s1_vld_d) begin
        s1_mode_q <= mode;
        s1_col_q  <= s1_col_d;
        s1_l_q    <= win_c_q;
        s1_c_q    <= win_r_q;
        s1_r_q    <= s1_r_d;
      end
    end
  end

  // Unpack the window into zero-extended signed taps.
  assign tl = $signed(SW'(s1_l_q[COLP-1 -: PIX_W]));
  assign ml = $signed(SW'(s1_l_q[2*PIX_W-1 -: PIX_W]));
  assign bl = $signed(SW'(s1_l_q[PIX_W-1:0]));
  assign tc = $signed(SW'(s1_c_q[COLP-1 -: PIX_W]));
  assign mc = $signed(SW'(s1_c_q[2*PIX_W-1 -: PIX_W]));
  assign bc = $signed(SW'(s1_c_q[PIX_W-1:0]));
  assign tr = $signed(SW'(s1_r_q[COLP-1 -: PIX_W]));
  assign mr = $signed(SW'(s1_r_q[2*PIX_W-1 -: PIX_W]));
  assign br = $signed(SW'(s1_r_q[PIX_W-1:0]));

  // Kernel sums. Blur peaks at 4080, sobel-x lies in +/-1020, sharpen in -1020..1275.
  always_comb begin
    s2_val_d = '0;
    case (s1_mode_q)
      2'b00:   s2_val_d = mc;
      2'b01:   s2_val_d = tl + 13'sd2 * ml + bl
                        + 13'sd2 * tc + 13'sd4 * mc + 13'sd2 * bc
                        + tr + 13'sd2 * mr + br;
      2'b10:   s2_val_d = (tr + 13'sd2 * mr + br) - (tl + 13'sd2 * ml + bl);
      default: s2_val_d = 13'sd5 * mc - tc - bc - ml - mr;
    endcase
  end

  // Stage 2: register the kernel sum with its mode and column tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_mode_q <= '0;
      s2_col_q  <= '0;
      s2_val_q  <= '0;
    end else if (start) begin
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_mode_q <= s1_mode_q;
        s2_col_q  <= s1_col_q;
        s2_val_q  <= s2_val_d;
      end
    end
  end

  assign abs_v = s2_val_q[SW-1] ? -s2_val_q : s2_val_q;

  // Normalise each mode's sum into an 8-bit pixel.
  always_comb begin
    pix_d = '0;
    case (s2_mode_q)
      2'b00:   pix_d = PIX_W'(s2_val_q);
      2'b01:   pix_d = PIX_W'((s2_val_q + 13'sd8) >>> 4);
      2'b10:   pix_d = (abs_v > 13'sd255) ? 8'd255 : PIX_W'(abs_v);
      default: begin
        if (s2_val_q < 13'sd0)        pix_d = 8'd0;
        else if (s2_val_q > 13'sd255) pix_d = 8'd255;
        else                          pix_d = PIX_W'(s2_val_q);
      end
    endcase
  end

  // Stage 3: output registers. Pixel and column hold their last value while not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_col   <= '0;
    end else if (start) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= s2_vld_q;
      if (s2_vld_q) begin
        out_pix <= pix_d;
        out_col <= s2_col_q;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_window.sv
// Scoreboard bench for conv3x3_window: directed column streams push the expected pixels into a
// queue. A negedge monitor pops one entry and compares it against each out_valid pixel.
module tb_conv3x3_window;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] bank0_pix, bank1_pix, bank2_pix;
  logic [2:0] top_sel;
  logic [1:0] mode;
  logic       out_valid;
  logic [7:0] out_pix, out_col;

  typedef struct {int col; int pix; int tid;} exp_t;
  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int tid    = 0;
  int acc_cyc[256];
  int out_cyc[256];

  conv3x3_window #(.IMG_W(256), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .bank0_pix(bank0_pix), .bank1_pix(bank1_pix), .bank2_pix(bank2_pix),
    .top_sel(top_sel), .mode(mode),
    .out_valid(out_valid), .out_pix(out_pix), .out_col(out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per output pixel, checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      out_cyc[out_col] = cyc;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_out: got col=%0d pix=%0d, required no output", out_col, out_pix);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(out_col) != e.col || int'(out_pix) != e.pix) begin
          n_miss++;
          $display("FAIL test%0d_pix: got col=%0d pix=%0d, required col=%0d pix=%0d",
                   e.tid, out_col, out_pix, e.col, e.pix);
        end else begin
          $display("test%0d out col=%0d pix=%0d ok", e.tid, out_col, out_pix);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("%s = %0d ok", name, act);
    end
  endtask

  task automatic push(input int c, input int p);
    exp_t e;
    e.col = c; e.pix = p; e.tid = tid;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                      input logic [2:0] ts, input logic [1:0] m);
    bank0_pix = p0; bank1_pix = p1; bank2_pix = p2;
    top_sel = ts; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check($sformatf("test%0d_drain_empty", tid), exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    bank0_pix = 0; bank1_pix = 0; bank2_pix = 0; top_sel = 3'b001; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pix", int'(out_pix), 0);
    check("reset_out_col", int'(out_col), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: flat 0x40 field through the blur kernel stays 0x40 on every column.
    tid = 1;
    for (int k = 0; k < 256; k++) push(k, 8'h40);
    for (int k = 0; k < 256; k++) beat(8'h40, 8'h40, 8'h40, 3'b001, 2'b01);
    drain(8);

    // 2: ramp in pass mode, with latency of the first pixel and the flushed last pixel.
    tid = 2;
    for (int k = 0; k < 256; k++) push(k, k);
    for (int k = 0; k < 256; k++) begin
      beat(8'(k), 8'(k), 8'(k), 3'b001, 2'b00);
      acc_cyc[k] = cyc;
    end
    drain(8);
    check("test2_first_latency", out_cyc[0] - acc_cyc[1], 2);
    check("test2_flush_after_254", out_cyc[255] - out_cyc[254], 1);
    check("test2_flush_latency", out_cyc[255] - acc_cyc[255], 3);

    // 3: sobel-x across a 0/255 step at column 128; both replicated edges give 0.
    tid = 3;
    for (int k = 0; k < 256; k++) push(k, (k == 127 || k == 128) ? 255 : 0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] v;
      v = (k < 128) ? 8'd0 : 8'd255;
      beat(v, v, v, 3'b001, 2'b10);
    end
    drain(8);

    // 4: sharpen on an isolated mid-row spike; its neighbours clamp to 0.
    tid = 4;
    pulse_start();
    for (int k = 0; k < 13; k++) push(k, (k == 10) ? 255 : 0);
    for (int k = 0; k < 14; k++) beat(8'd0, (k == 10) ? 8'd255 : 8'd0, 8'd0, 3'b001, 2'b11);
    drain(6);

    // 5: row rotation; 010 puts bank2 in the middle, 101 falls back to bank1.
    tid = 5;
    pulse_start();
    push(0, 2); push(1, 2);
    for (int k = 0; k < 3; k++) beat(8'd3, 8'd1, 8'd2, 3'b010, 2'b00);
    drain(6);
    pulse_start();
    push(0, 1); push(1, 1);
    for (int k = 0; k < 3; k++) beat(8'd3, 8'd1, 8'd2, 3'b101, 2'b00);
    drain(6);

    // 6: start after 100 beats drops in-flight pixels, beats restart at column 0.
    tid = 6;
    pulse_start();
    for (int k = 0; k < 97; k++) push(k, k);
    for (int k = 0; k < 100; k++) beat(8'(k), 8'(k), 8'(k), 3'b001, 2'b00);
    bank0_pix = 8'd250; bank1_pix = 8'd250; bank2_pix = 8'd250;
    start = 1'b1;                      // in_valid still high: start must win
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    check("test6_valid_after_start", int'(out_valid), 0);
    check("test6_queue_after_start", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) push(k, 200 + k);
    for (int k = 0; k < 5; k++) beat(8'(200 + k), 8'(200 + k), 8'(200 + k), 3'b001, 2'b00);
    drain(6);
    check("test6_hold_pix", int'(out_pix), 203);
    check("test6_hold_col", int'(out_col), 3);

    // Asynchronous reset clears the outputs without waiting for a clock edge.
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_pix", int'(out_pix), 0);
    check("async_rst_out_col", int'(out_col), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
